// File: rtl/seg7_reader_3bits.sv
// ---------------------------------------------------------------------------
// seg7_reader_3bits
//   Watches a 7-segment display bus and recovers the 3-bit digit (0-7) it
//   shows. The sampled lines are debounced by requiring STABLE_CYCLES
//   identical samples in a row. Each settled pattern is classified as a digit,
//   a blank display, or an error. The result is offered on a valid/ready
//   handshake. Accepted error results are counted, saturating at 255.
//
// Parameters
//   STABLE_CYCLES  : identical samples needed before a pattern counts as
//                    settled (1..255)
//   EMIT_ON_CHANGE : 1 = only emit when the settled pattern differs from the
//                    last accepted one; 0 = emit once per stability episode
//
// Ports
//   clk            : system clock, rising edge
//   rst_n          : synchronous active-low reset
//   seg_a..seg_g   : segment lines a (top) through g (middle)
//   seg_dp         : decimal point line
//   out_ready      : consumer accepts the presented result
//   out_valid      : a result is being presented
//   out_value      : decoded digit, 0 for blank/error
//   out_blank      : settled pattern was all-off
//   out_error      : settled pattern was neither a digit nor blank
//   out_err_count  : number of accepted error results, saturating at 255
// ---------------------------------------------------------------------------
module seg7_reader_3bits #(
  parameter int STABLE_CYCLES  = 4,
  parameter int EMIT_ON_CHANGE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_a,
  input  logic       seg_b,
  input  logic       seg_c,
  input  logic       seg_d,
  input  logic       seg_e,
  input  logic       seg_f,
  input  logic       seg_g,
  input  logic       seg_dp,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_value,
  output logic       out_blank,
  output logic       out_error,
  output logic [7:0] out_err_count
);

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  typedef enum logic {
    SETTLE = 1'b0,
    EMIT   = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] sample;
  logic [7:0] cand;
  logic [7:0] cnt;
  logic [7:0] last_acc;
  logic [7:0] held_pat;
  logic       first;
  logic       episode_done;

  logic       settled;
  logic       emit_permitted;
  logic       do_emit;
  logic       do_accept;

  logic [2:0] dec_value;
  logic       dec_blank;
  logic       dec_error;

  // Bit order {dp,g,f,e,d,c,b,a} so the low seven bits read as the usual
  // segment encoding.
  assign sample  = {seg_dp, seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};
  assign settled = (cnt == STABLE_LIMIT);

  // Classify the current candidate pattern. A lit decimal point is never part
  // of a legal digit, so it forces an error regardless of the other lines.
  always_comb begin
    dec_value = 3'd0;
    dec_blank = 1'b0;
    dec_error = 1'b0;
    if (cand[7]) begin
      dec_error = 1'b1;
    end else begin
      case (cand[6:0])
        7'h3F:   dec_value = 3'd0;
        7'h06:   dec_value = 3'd1;
        7'h5B:   dec_value = 3'd2;
        7'h4F:   dec_value = 3'd3;
        7'h66:   dec_value = 3'd4;
        7'h6D:   dec_value = 3'd5;
        7'h7D:   dec_value = 3'd6;
        7'h07:   dec_value = 3'd7;
        7'h00:   dec_blank = 1'b1;
        default: dec_error = 1'b1;
      endcase
    end
  end

  // Next-state logic: emit from SETTLE when a permitted pattern has settled,
  // return to SETTLE on the accepting edge.
  always_comb begin
    state_next     = state;
    do_emit        = 1'b0;
    do_accept      = 1'b0;
    emit_permitted = 1'b0;
    if (EMIT_ON_CHANGE != 0) begin
      emit_permitted = first || (cand != last_acc);
    end else begin
      emit_permitted = !episode_done;
    end
    case (state)
      SETTLE: begin
        if (settled && emit_permitted) begin
          do_emit    = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          do_accept  = 1'b1;
          state_next = SETTLE;
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  // Sampler, held result and bookkeeping. The sampler runs in every state;
  // a pattern change clears episode_done even on the accepting edge, so a
  // change that coincides with acceptance starts a fresh episode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= SETTLE;
      cand          <= 8'h00;
      cnt           <= 8'd0;
      first         <= 1'b1;
      episode_done  <= 1'b0;
      last_acc      <= 8'h00;
      held_pat      <= 8'h00;
      out_valid     <= 1'b0;
      out_value     <= 3'd0;
      out_blank     <= 1'b0;
      out_error     <= 1'b0;
      out_err_count <= 8'd0;
    end else begin
      state <= state_next;

      if (sample != cand) begin
        cand         <= sample;
        cnt          <= 8'd1;
        episode_done <= 1'b0;
      end else begin
        if (cnt < STABLE_LIMIT) begin
          cnt <= cnt + 8'd1;
        end
        if (do_accept) begin
          episode_done <= 1'b1;
        end
      end

      if (do_emit) begin
        out_valid <= 1'b1;
        out_value <= dec_value;
        out_blank <= dec_blank;
        out_error <= dec_error;
        held_pat  <= cand;
      end

      if (do_accept) begin
        out_valid <= 1'b0;
        last_acc  <= held_pat;
        first     <= 1'b0;
        if (out_error && (out_err_count != 8'hFF)) begin
          out_err_count <= out_err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader_3bits.sv
// ---------------------------------------------------------------------------
// tb_seg7_reader_3bits
//   Drives three copies of the reader from one shared segment bus:
//     u0 : STABLE_CYCLES=4, EMIT_ON_CHANGE=1
//     u1 : STABLE_CYCLES=4, EMIT_ON_CHANGE=0
//     u2 : STABLE_CYCLES=1, EMIT_ON_CHANGE=1
//   A reference model keeps the sample history since reset and derives the
//   expected handshake of every copy from it; it is compared every cycle.
//   Directed sequences add hand-derived expectations on top.
// ---------------------------------------------------------------------------
module tb_seg7_reader_3bits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_bus;
  logic       out_ready;

  logic       out_valid_w     [3];
  logic [2:0] out_value_w     [3];
  logic       out_blank_w     [3];
  logic       out_error_w     [3];
  logic [7:0] out_err_count_w [3];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  seg7_reader_3bits #(.STABLE_CYCLES(4), .EMIT_ON_CHANGE(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .seg_a(seg_bus[0]), .seg_b(seg_bus[1]), .seg_c(seg_bus[2]), .seg_d(seg_bus[3]),
    .seg_e(seg_bus[4]), .seg_f(seg_bus[5]), .seg_g(seg_bus[6]), .seg_dp(seg_bus[7]),
    .out_ready(out_ready), .out_valid(out_valid_w[0]), .out_value(out_value_w[0]),
    .out_blank(out_blank_w[0]), .out_error(out_error_w[0]), .out_err_count(out_err_count_w[0])
  );

  seg7_reader_3bits #(.STABLE_CYCLES(4), .EMIT_ON_CHANGE(0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .seg_a(seg_bus[0]), .seg_b(seg_bus[1]), .seg_c(seg_bus[2]), .seg_d(seg_bus[3]),
    .seg_e(seg_bus[4]), .seg_f(seg_bus[5]), .seg_g(seg_bus[6]), .seg_dp(seg_bus[7]),
    .out_ready(out_ready), .out_valid(out_valid_w[1]), .out_value(out_value_w[1]),
    .out_blank(out_blank_w[1]), .out_error(out_error_w[1]), .out_err_count(out_err_count_w[1])
  );

  seg7_reader_3bits #(.STABLE_CYCLES(1), .EMIT_ON_CHANGE(1)) u2 (
    .clk(clk), .rst_n(rst_n),
    .seg_a(seg_bus[0]), .seg_b(seg_bus[1]), .seg_c(seg_bus[2]), .seg_d(seg_bus[3]),
    .seg_e(seg_bus[4]), .seg_f(seg_bus[5]), .seg_g(seg_bus[6]), .seg_dp(seg_bus[7]),
    .out_ready(out_ready), .out_valid(out_valid_w[2]), .out_value(out_value_w[2]),
    .out_blank(out_blank_w[2]), .out_error(out_error_w[2]), .out_err_count(out_err_count_w[2])
  );

  // Segment patterns {dp,g,f,e,d,c,b,a} for digits 0..7.
  logic [7:0] digit_pat [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};

  // ---------------- reference model ----------------
  int         stable_of [3] = '{4, 4, 1};
  int         mode_of   [3] = '{1, 0, 1};
  logic [7:0] hist [$];
  int         sample_no = 0;
  int         run_start = 0;
  bit         m_valid     [3] = '{0, 0, 0};
  logic [7:0] m_pat       [3];
  logic [7:0] m_last      [3];
  bit         m_first     [3] = '{1, 1, 1};
  int         m_acc_start [3] = '{-1, -1, -1};
  int         m_errcnt    [3] = '{0, 0, 0};

  task automatic decodeRef(input logic [7:0] pat, output logic [2:0] v,
                           output logic b, output logic e);
    v = 3'd0;
    b = 1'b0;
    e = 1'b0;
    if (pat == 8'h00) begin
      b = 1'b1;
    end else begin
      e = 1'b1;
      for (int d = 0; d < 8; d++) begin
        if (pat == digit_pat[d]) begin
          v = 3'(d);
          e = 1'b0;
        end
      end
    end
  endtask

  // Length of the trailing run of identical samples since reset, capped.
  function automatic int runLen(input int cap);
    int n;
    int k;
    n = 0;
    k = hist.size() - 1;
    while (k >= 0 && n < cap && hist[k] == hist[hist.size() - 1]) begin
      n++;
      k--;
    end
    return n;
  endfunction

  task automatic modelStep();
    logic [7:0] smp;
    logic [7:0] cand_now;
    bit         permit;
    logic [2:0] v;
    logic       b;
    logic       e;
    smp = seg_bus;
    if (!rst_n) begin
      hist.delete();
      run_start = sample_no;
      for (int i = 0; i < 3; i++) begin
        m_valid[i]     = 1'b0;
        m_errcnt[i]    = 0;
        m_first[i]     = 1'b1;
        m_acc_start[i] = -1;
        m_last[i]      = 8'h00;
      end
    end else begin
      cand_now = (hist.size() == 0) ? 8'h00 : hist[hist.size() - 1];
      for (int i = 0; i < 3; i++) begin
        if (!m_valid[i]) begin
          if (mode_of[i] == 1) permit = m_first[i] || (cand_now != m_last[i]);
          else                 permit = (m_acc_start[i] != run_start);
          if (runLen(stable_of[i]) == stable_of[i] && permit) begin
            m_valid[i] = 1'b1;
            m_pat[i]   = cand_now;
          end
        end else if (out_ready) begin
          m_valid[i]     = 1'b0;
          m_last[i]      = m_pat[i];
          m_first[i]     = 1'b0;
          m_acc_start[i] = run_start;
          decodeRef(m_pat[i], v, b, e);
          if (e && m_errcnt[i] < 255) m_errcnt[i]++;
        end
      end
      if (smp != cand_now) run_start = sample_no;
      hist.push_back(smp);
      if (hist.size() > 300) void'(hist.pop_front());
    end
    sample_no++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model advances on each edge and all three copies are compared 1 time unit later.
  always begin
    logic [2:0] v;
    logic       b;
    logic       e;
    @(posedge clk);
    modelStep();
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("m%0d_valid", i), 32'(out_valid_w[i]), 32'(m_valid[i]));
      checkOutput($sformatf("m%0d_errcnt", i), 32'(out_err_count_w[i]), 32'(m_errcnt[i]));
      if (m_valid[i]) begin
        decodeRef(m_pat[i], v, b, e);
        checkOutput($sformatf("m%0d_value", i), 32'(out_value_w[i]), 32'(v));
        checkOutput($sformatf("m%0d_blank", i), 32'(out_blank_w[i]), 32'(b));
        checkOutput($sformatf("m%0d_error", i), 32'(out_error_w[i]), 32'(e));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic [7:0] pat, input logic rdy);
    @(negedge clk);
    seg_bus   = pat;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    seg_bus   = 8'h00;
    out_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitValid0(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (out_valid_w[0]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [2:0] value;
    logic       blank;
    logic       error;
  } vec_t;

  vec_t vecs [14];
  bit   seen;

  initial begin
    vecs[0]  = '{8'h00, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{8'h3F, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{8'h06, 3'd1, 1'b0, 1'b0};
    vecs[3]  = '{8'h5B, 3'd2, 1'b0, 1'b0};
    vecs[4]  = '{8'h4F, 3'd3, 1'b0, 1'b0};
    vecs[5]  = '{8'h66, 3'd4, 1'b0, 1'b0};
    vecs[6]  = '{8'h6D, 3'd5, 1'b0, 1'b0};
    vecs[7]  = '{8'h7D, 3'd6, 1'b0, 1'b0};
    vecs[8]  = '{8'h07, 3'd7, 1'b0, 1'b0};
    vecs[9]  = '{8'hBF, 3'd0, 1'b0, 1'b1};
    vecs[10] = '{8'h41, 3'd0, 1'b0, 1'b1};
    vecs[11] = '{8'hFF, 3'd0, 1'b0, 1'b1};
    vecs[12] = '{8'h86, 3'd0, 1'b0, 1'b1};
    vecs[13] = '{8'h01, 3'd0, 1'b0, 1'b1};

    // Reset, then a blank display settles 5 edges after release.
    $display("[TB] reset behaviour");
    rst_n     = 1'b0;
    seg_bus   = 8'h00;
    out_ready = 1'b1;
    repeat (2) tick();
    checkOutput("rst_valid", 32'(out_valid_w[0]), 32'd0);
    checkOutput("rst_value", 32'(out_value_w[0]), 32'd0);
    checkOutput("rst_blank", 32'(out_blank_w[0]), 32'd0);
    checkOutput("rst_error", 32'(out_error_w[0]), 32'd0);
    checkOutput("rst_errcnt", 32'(out_err_count_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("rel_valid_e%0d", k), 32'(out_valid_w[0]), 32'(k == 5));
      if (k == 5) begin
        checkOutput("rel_blank", 32'(out_blank_w[0]), 32'd1);
        checkOutput("rel_value", 32'(out_value_w[0]), 32'd0);
      end
    end

    // Digit 6 held while the lines move to 1; 1 follows acceptance.
    $display("[TB] digit 6 hold");
    for (int k = 0; k <= 4; k++) begin
      applyStimulus(8'h7D, 1'b0);
      tick();
      checkOutput($sformatf("d6_valid_k%0d", k), 32'(out_valid_w[0]), 32'(k == 4));
    end
    checkOutput("d6_value", 32'(out_value_w[0]), 32'd6);
    checkOutput("d6_error", 32'(out_error_w[0]), 32'd0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(8'h06, 1'b0);
      tick();
      checkOutput("d6_hold_valid", 32'(out_valid_w[0]), 32'd1);
      checkOutput("d6_hold_value", 32'(out_value_w[0]), 32'd6);
    end
    applyStimulus(8'h06, 1'b1);
    tick();
    checkOutput("d6_acc_valid", 32'(out_valid_w[0]), 32'd0);
    tick();
    checkOutput("d1_valid", 32'(out_valid_w[0]), 32'd1);
    checkOutput("d1_value", 32'(out_value_w[0]), 32'd1);
    tick();
    checkOutput("d1_acc_valid", 32'(out_valid_w[0]), 32'd0);

    // Glitch of 3 samples: dropped by u0, re-episode on u1.
    $display("[TB] glitch rejection");
    applyStimulus(8'h5B, 1'b1);
    waitValid0(12, seen);
    checkOutput("g_seen", 32'(seen), 32'd1);
    checkOutput("g_value", 32'(out_value_w[0]), 32'd2);
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'h4F, 1'b1);
      tick();
      checkOutput("g_pulse_valid", 32'(out_valid_w[0]), 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      applyStimulus(8'h5B, 1'b1);
      tick();
      checkOutput($sformatf("g_u0_valid_k%0d", k), 32'(out_valid_w[0]), 32'd0);
      checkOutput($sformatf("g_u1_valid_k%0d", k), 32'(out_valid_w[1]), 32'(k == 4));
      if (k == 4) checkOutput("g_u1_value", 32'(out_value_w[1]), 32'd2);
    end

    // Decode table, one settled result per row.
    $display("[TB] decode table");
    doReset();
    for (int r = 0; r < 14; r++) begin
      applyStimulus(vecs[r].pat, 1'b1);
      waitValid0(12, seen);
      checkOutput($sformatf("tab%0d_seen", r), 32'(seen), 32'd1);
      checkOutput($sformatf("tab%0d_value", r), 32'(out_value_w[0]), 32'(vecs[r].value));
      checkOutput($sformatf("tab%0d_blank", r), 32'(out_blank_w[0]), 32'(vecs[r].blank));
      checkOutput($sformatf("tab%0d_error", r), 32'(out_error_w[0]), 32'(vecs[r].error));
      tick();
      checkOutput($sformatf("tab%0d_acc", r), 32'(out_valid_w[0]), 32'd0);
    end

    // Error path and saturation of the error counter.
    $display("[TB] error path");
    doReset();
    applyStimulus(8'hBF, 1'b1);
    waitValid0(12, seen);
    checkOutput("e1_seen", 32'(seen), 32'd1);
    checkOutput("e1_error", 32'(out_error_w[0]), 32'd1);
    checkOutput("e1_value", 32'(out_value_w[0]), 32'd0);
    checkOutput("e1_cnt_pre", 32'(out_err_count_w[0]), 32'd0);
    tick();
    checkOutput("e1_cnt", 32'(out_err_count_w[0]), 32'd1);
    applyStimulus(8'h41, 1'b1);
    waitValid0(12, seen);
    checkOutput("e2_seen", 32'(seen), 32'd1);
    checkOutput("e2_error", 32'(out_error_w[0]), 32'd1);
    checkOutput("e2_value", 32'(out_value_w[0]), 32'd0);
    tick();
    checkOutput("e2_cnt", 32'(out_err_count_w[0]), 32'd2);
    for (int i = 0; i < 260; i++) begin
      applyStimulus((i % 2 == 0) ? 8'hBF : 8'h41, 1'b1);
      waitValid0(12, seen);
      checkOutput("esat_seen", 32'(seen), 32'd1);
      tick();
    end
    checkOutput("esat_cnt", 32'(out_err_count_w[0]), 32'd255);
    applyStimulus(8'hBF, 1'b1);
    waitValid0(12, seen);
    tick();
    checkOutput("esat_cnt_hold", 32'(out_err_count_w[0]), 32'd255);

    // Reset while a result is held discards it; 7 is emitted again.
    $display("[TB] reset mid-emit");
    applyStimulus(8'h07, 1'b0);
    waitValid0(12, seen);
    checkOutput("r7_seen", 32'(seen), 32'd1);
    checkOutput("r7_value", 32'(out_value_w[0]), 32'd7);
    repeat (3) tick();
    checkOutput("r7_held", 32'(out_valid_w[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    checkOutput("r7_rst_valid", 32'(out_valid_w[0]), 32'd0);
    checkOutput("r7_rst_cnt", 32'(out_err_count_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("r7_again_e%0d", k), 32'(out_valid_w[0]), 32'(k == 5));
    end
    checkOutput("r7_again_value", 32'(out_value_w[0]), 32'd7);
    applyStimulus(8'h07, 1'b1);
    repeat (10) tick();

    // STABLE_CYCLES=1 copy: a new digit every 2 cycles, each emitted at N+1.
    $display("[TB] single-sample settle");
    for (int d = 0; d < 8; d++) begin
      applyStimulus(digit_pat[d], 1'b1);
      tick();
      checkOutput($sformatf("s1_d%0d_n", d), 32'(out_valid_w[2]), 32'd0);
      tick();
      checkOutput($sformatf("s1_d%0d_n1", d), 32'(out_valid_w[2]), 32'd1);
      checkOutput($sformatf("s1_d%0d_val", d), 32'(out_value_w[2]), 32'(d));
    end

    // Randomised patterns, hold lengths, ready and occasional reset.
    $display("[TB] random phase");
    for (int c = 0; c < 4000; ) begin
      logic [7:0] pat;
      int         r;
      int         hold;
      r = $urandom_range(0, 9);
      if (r < 7)       pat = digit_pat[$urandom_range(0, 7)];
      else if (r == 7) pat = 8'h00;
      else if (r == 8) pat = 8'($urandom);
      else             pat = digit_pat[$urandom_range(0, 7)] | 8'h80;
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        seg_bus   = pat;
        out_ready = ($urandom_range(0, 3) != 0);
        rst_n     = ($urandom_range(0, 299) != 0);
        c++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
